// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, precharge level and parity helper for sram_bank
package sram_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PRE,
    ACT,
    SENSE,
    WR
  } state_t;

  // Bitlines idle at this level between accesses
  localparam logic PRECHARGE_LVL = 1'b1;

  // Even parity; callers zero-extend their word to 64 bits
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_bank_if.sv
// rtl/sram_bank_if.sv - request/response port of sram_bank; perr only with SRAM_BANK_PARITY_EN
interface sram_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
`ifdef SRAM_BANK_PARITY_EN
  logic              perr;
`endif

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
`ifdef SRAM_BANK_PARITY_EN
    , input perr
`endif
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
`ifdef SRAM_BANK_PARITY_EN
    , output perr
`endif
  );

endinterface

// File: rtl/sram_sense_amp.sv
// rtl/sram_sense_amp.sv - resolves a bitline pair per column into registered read data
// Parity check against the stored column is built only with SRAM_BANK_PARITY_EN.
module sram_sense_amp
  import sram_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] blb,
  output logic [DATA_W-1:0] rdata,
`ifdef SRAM_BANK_PARITY_EN
  input  logic              par,
  output logic              perr,
`endif
  output logic              rvalid
);

  logic [DATA_W-1:0] resolved;

  // A column reads 1 only when the pair has split with bl high
  assign resolved = bl & ~blb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= en;
      if (en) begin
        rdata <= resolved;
      end
    end
  end

`ifdef SRAM_BANK_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else begin
      perr <= en && (even_parity(64'(resolved)) != par);
    end
  end
`endif

endmodule

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - single-port SRAM bank: init sweep, precharge/wordline/sense access FSM
// Optional parity column enabled by SRAM_BANK_PARITY_EN.
module sram_bank
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic        clk,
  input logic        rst,
  sram_bank_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] row_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] row_sel;
  logic [DEPTH-1:0]  wordline;
  logic [DATA_W-1:0] cell_row;
  logic [DATA_W-1:0] bl;
  logic [DATA_W-1:0] blb;
  logic              array_we;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      row_cnt   <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        row_cnt <= row_cnt + 1'b1;
      end
      if (state == IDLE && bus.req) begin
        lat_addr  <= bus.addr;
        lat_we    <= bus.we;
        lat_wdata <= bus.wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (row_cnt == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      IDLE:    if (bus.req) state_nxt = PRE;
      PRE:     state_nxt = lat_we ? WR : ACT;
      ACT:     state_nxt = SENSE;
      SENSE:   state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  assign row_sel  = (state == INIT) ? row_cnt : lat_addr;
  assign array_we = (state == INIT) || (state == WR);

  // Wordline stays raised through SENSE so the pair is still split when sampled
  always_comb begin
    wordline = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wordline[r] = (row_sel == ADDR_W'(r)) &&
                    (state == INIT || state == ACT || state == SENSE || state == WR);
    end
  end

  always_comb begin
    cell_row = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (wordline[r]) cell_row = cell_row | mem[r];
    end
  end

  always_comb begin
    bl  = {DATA_W{PRECHARGE_LVL}};
    blb = {DATA_W{PRECHARGE_LVL}};
    case (state)
      INIT: begin
        bl  = '0;
        blb = '1;
      end
      ACT, SENSE: begin
        bl  = cell_row;
        blb = ~cell_row;
      end
      WR: begin
        bl  = lat_wdata;
        blb = ~lat_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (array_we) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wordline[r]) mem[r] <= bl;
      end
    end
  end

`ifdef SRAM_BANK_PARITY_EN
  logic par_mem [DEPTH];
  logic par_wr;
  logic par_cell;

  assign par_wr = (state == WR) ? even_parity(64'(bl)) : 1'b0;

  always_comb begin
    par_cell = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (wordline[r]) par_cell = par_cell | par_mem[r];
    end
  end

  always_ff @(posedge clk) begin
    if (array_we) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wordline[r]) par_mem[r] <= par_wr;
      end
    end
  end
`endif

  assign bus.ready = (state == IDLE);

  sram_sense_amp #(
    .DATA_W(DATA_W)
  ) u_sense_amp (
    .clk    (clk),
    .rst    (rst),
    .en     (state == SENSE),
    .bl     (bl),
    .blb    (blb),
    .rdata  (bus.rdata),
`ifdef SRAM_BANK_PARITY_EN
    .par    (par_cell),
    .perr   (bus.perr),
`endif
    .rvalid (bus.rvalid)
  );

endmodule

// File: tb/tb_sram_bank.sv
// tb/tb_sram_bank.sv - randomized transaction-level check of sram_bank against a reference model
module tb_sram_bank;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sram_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: row contents plus occupancy/latency counters
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_flip [DEPTH];
  int                m_init;
  int                m_busy;
  int                m_rdcnt;
  logic [DATA_W-1:0] m_rd_pend;
  logic [DATA_W-1:0] m_rdata;
  bit                m_rv;
  bit                m_perr;
  bit                m_perr_pend;
  int                acc_reads = 0;
  int                seen_rv   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = '0;
      m_flip[r] = 1'b0;
    end
    m_init      = DEPTH;
    m_busy      = 0;
    m_rdcnt     = 0;
    m_rdata     = '0;
    m_rv        = 1'b0;
    m_perr      = 1'b0;
    m_perr_pend = 1'b0;
  endfunction

  function automatic bit m_ready();
    return (m_init == 0) && (m_busy == 0);
  endfunction

  task automatic check_outputs();
    check("ready",  32'(bus.ready),  32'(m_ready()));
    check("rvalid", 32'(bus.rvalid), 32'(m_rv));
    check("rdata",  32'(bus.rdata),  32'(m_rdata));
`ifdef SRAM_BANK_PARITY_EN
    check("perr",   32'(bus.perr),   32'(m_perr));
`endif
  endtask

  // One clock: drive inputs, advance model across the edge, compare
  task automatic step(input bit rq, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    bit acc;
    bus.req   = rq;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    acc = m_ready() && rq && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_rv   = 1'b0;
      m_perr = 1'b0;
      if (m_rdcnt > 0) begin
        m_rdcnt--;
        if (m_rdcnt == 0) begin
          m_rv    = 1'b1;
          m_rdata = m_rd_pend;
          m_perr  = m_perr_pend;
        end
      end
      if (m_init > 0) m_init--;
      if (m_busy > 0) m_busy--;
      if (acc) begin
        if (w) begin
          m_mem[a]  = d;
          m_flip[a] = 1'b0;
          m_busy    = 2;
        end else begin
          m_rd_pend   = m_mem[a];
          m_perr_pend = m_flip[a];
          m_rdcnt     = 3;
          m_busy      = 3;
          acc_reads++;
        end
      end
    end
    if (bus.rvalid) seen_rv++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic access(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int guard = 0;
    while (!m_ready() && guard < 50) begin
      step(1'b0, 1'b0, '0, '0);
      guard++;
    end
    check("access_wait", 32'(guard < 50), 32'd1);
    step(1'b1, w, a, d);
  endtask

  task automatic reset_bank(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    int rd_base;
    int rv_base;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    model_reset();
    idle(3);
    rst = 1'b0;

    // Init sweep, then every row reads back zero
    idle(20);
    for (int r = 0; r < DEPTH; r++) access(1'b0, ADDR_W'(r), '0);
    idle(5);

    access(1'b1, 4'd3, 8'hA5);
    access(1'b0, 4'd3, '0);
    access(1'b0, 4'd4, '0);
    idle(5);

    // Address extremes back to back
    access(1'b1, 4'd15, 8'hFF);
    access(1'b1, 4'd0,  8'h01);
    access(1'b0, 4'd15, '0);
    access(1'b0, 4'd0,  '0);
    idle(5);

    // Requests held through busy cycles with changing fields
    rd_base = acc_reads;
    rv_base = seen_rv;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           ADDR_W'($urandom), DATA_W'($urandom));
    end
    idle(5);
    check("rvalid_count", 32'(seen_rv - rv_base), 32'(acc_reads - rd_base));

    // Reset while a read of row 2 sits in ACT
    access(1'b1, 4'd2, 8'h3C);
    access(1'b0, 4'd2, '0);
    idle(1);
    reset_bank(2);
    idle(20);
    access(1'b0, 4'd2, '0);
    idle(5);

`ifdef SRAM_BANK_PARITY_EN
    access(1'b1, 4'd5, 8'h07);
    access(1'b1, 4'd6, 8'h07);
    idle(3);
    dut.par_mem[5] = ~dut.par_mem[5];
    m_flip[5] = 1'b1;
    access(1'b0, 4'd5, '0);
    access(1'b0, 4'd6, '0);
    idle(5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
